// File: rtl/gpmc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gpmc_pkg
// Description : Shared definitions for the GPMC register bank: FSM state
//               encoding, default identification value and the read-only
//               address helper.
// Revision    : 1.0  initial release
// ============================================================================
package gpmc_pkg;

  // FSM state encoding (3 bits wide)
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ADDR  = 3'd1;
  localparam logic [2:0] ST_CMD   = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_READ  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_ADDR  = ST_ADDR,
    S_CMD   = ST_CMD,
    S_WRITE = ST_WRITE,
    S_READ  = ST_READ
  } gpmc_state_e;

  // Value returned from the top address of the bank.
  localparam logic [15:0] GPMC_ID_DEFAULT = 16'hB33F;

  // Addresses at or above the R/W window are status / ID registers.
  function automatic logic is_ro_addr(input int unsigned addr,
                                      input int unsigned num_rw);
    return (addr >= num_rw);
  endfunction

endpackage
`default_nettype wire

// File: rtl/gpmc_sync.sv
`default_nettype none
// ============================================================================
// Module      : gpmc_sync
// Description : WIDTH-bit SYNC_STAGES-deep synchroniser with one extra delay
//               flop on the last stage, producing per-bit rising and falling
//               edge flags. WIDTH=1 for a single strobe, wider for buses.
// Ports       : CLK_100M   - system clock
//               reset      - synchronous, active-high
//               async_i    - asynchronous input
//               sync_o     - last synchroniser stage
//               dly_o      - sync_o delayed by one cycle
//               rise_o     - sync_o high, dly_o low
//               fall_o     - sync_o low, dly_o high
// Revision    : 1.0  initial release
// ============================================================================
module gpmc_sync #(
  parameter int               WIDTH       = 1,
  parameter int               SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] RESET_VAL   = '0
) (
  input  logic             CLK_100M,
  input  logic             reset,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] sync_o,
  output logic [WIDTH-1:0] dly_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o
);

  logic [WIDTH-1:0] stage_q [SYNC_STAGES];
  logic [WIDTH-1:0] dly_q;

  // Reset value matches the idle level of the pin so that leaving reset
  // never manufactures a spurious edge.
  always_ff @(posedge CLK_100M) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        stage_q[i] <= RESET_VAL;
      end
      dly_q <= RESET_VAL;
    end else begin
      stage_q[0] <= async_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
      dly_q <= stage_q[SYNC_STAGES-1];
    end
  end

  assign sync_o = stage_q[SYNC_STAGES-1];
  assign dly_o  = dly_q;
  assign rise_o = stage_q[SYNC_STAGES-1] & ~dly_q;
  assign fall_o = ~stage_q[SYNC_STAGES-1] & dly_q;

endmodule
`default_nettype wire

// File: rtl/gpmc_regbank.sv
`default_nettype none
// ============================================================================
// Module      : gpmc_regbank
// Description : GPMC multiplexed address/data slave exposing NUM_RW control
//               registers, read-only status registers and an ID register at
//               the top address. All GPMC pins are synchronised into CLK_100M.
// Option      : GPMC_BYTE_LANE_EN - when defined and DATA_W=16, writes only
//               update byte lanes whose gpmc_ben bit is low.
// Ports       : CLK_100M          - system clock
//               reset             - synchronous, active-high
//               gpmc_ad_i/_o/_oe  - AD bus input, output and tristate enable
//               gpmc_advn/csn/wein/oen - active-low GPMC strobes
//               gpmc_ben          - active-low byte enables
//               ctrl_q            - flattened R/W register contents
//               status_i          - flattened status register inputs
//               wr_strobe         - one-cycle pulse per written register
//               proto_err         - sticky WE/OE overlap flag
// Revision    : 1.0  initial release
// ============================================================================
module gpmc_regbank
  import gpmc_pkg::*;
#(
  parameter int          DATA_W      = 16,
  parameter int          ADDR_W      = 4,
  parameter int          NUM_RW      = 8,
  parameter int          SYNC_STAGES = 2,
  parameter logic [15:0] ID_VALUE    = GPMC_ID_DEFAULT
) (
  input  logic                                      CLK_100M,
  input  logic                                      reset,
  input  logic [DATA_W-1:0]                         gpmc_ad_i,
  output logic [DATA_W-1:0]                         gpmc_ad_o,
  output logic                                      gpmc_ad_oe,
  input  logic                                      gpmc_advn,
  input  logic                                      gpmc_csn,
  input  logic                                      gpmc_wein,
  input  logic                                      gpmc_oen,
  input  logic [1:0]                                gpmc_ben,
  output logic [NUM_RW*DATA_W-1:0]                  ctrl_q,
  input  logic [(2**ADDR_W-NUM_RW-1)*DATA_W-1:0]    status_i,
  output logic [NUM_RW-1:0]                         wr_strobe,
  output logic                                      proto_err
);

  localparam int NUM_REGS = 2**ADDR_W;

  // --------------------------------------------------------------------------
  // Synchronisers
  // --------------------------------------------------------------------------
  logic csn_s,  csn_dly,  csn_rise,  csn_fall;
  logic advn_s, advn_dly, advn_rise, advn_fall;
  logic wein_s, wein_dly, wein_rise, wein_fall;
  logic oen_s,  oen_dly,  oen_rise,  oen_fall;
  logic [DATA_W-1:0] ad_s, ad_dly, ad_rise, ad_fall;
  logic [1:0]        ben_s, ben_dly, ben_rise, ben_fall;

  gpmc_sync #(.WIDTH(1), .SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_csn (
    .CLK_100M(CLK_100M), .reset(reset), .async_i(gpmc_csn),
    .sync_o(csn_s), .dly_o(csn_dly), .rise_o(csn_rise), .fall_o(csn_fall)
  );

  gpmc_sync #(.WIDTH(1), .SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_advn (
    .CLK_100M(CLK_100M), .reset(reset), .async_i(gpmc_advn),
    .sync_o(advn_s), .dly_o(advn_dly), .rise_o(advn_rise), .fall_o(advn_fall)
  );

  gpmc_sync #(.WIDTH(1), .SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_wein (
    .CLK_100M(CLK_100M), .reset(reset), .async_i(gpmc_wein),
    .sync_o(wein_s), .dly_o(wein_dly), .rise_o(wein_rise), .fall_o(wein_fall)
  );

  gpmc_sync #(.WIDTH(1), .SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_oen (
    .CLK_100M(CLK_100M), .reset(reset), .async_i(gpmc_oen),
    .sync_o(oen_s), .dly_o(oen_dly), .rise_o(oen_rise), .fall_o(oen_fall)
  );

  gpmc_sync #(.WIDTH(DATA_W), .SYNC_STAGES(SYNC_STAGES), .RESET_VAL('0)) u_sync_ad (
    .CLK_100M(CLK_100M), .reset(reset), .async_i(gpmc_ad_i),
    .sync_o(ad_s), .dly_o(ad_dly), .rise_o(ad_rise), .fall_o(ad_fall)
  );

  gpmc_sync #(.WIDTH(2), .SYNC_STAGES(SYNC_STAGES), .RESET_VAL(2'b11)) u_sync_ben (
    .CLK_100M(CLK_100M), .reset(reset), .async_i(gpmc_ben),
    .sync_o(ben_s), .dly_o(ben_dly), .rise_o(ben_rise), .fall_o(ben_fall)
  );

  // Synchroniser outputs this block has no use for.
  logic unused_sync;
  assign unused_sync = ^{csn_dly, csn_fall, advn_dly, advn_fall, wein_dly,
                         wein_fall, oen_dly, oen_fall, ad_s, ad_rise, ad_fall,
                         ben_s, ben_dly, ben_rise, ben_fall};

  // --------------------------------------------------------------------------
  // Byte-lane write mask. The *_dly copy lines up with the AD sample taken
  // the cycle before the WE rising edge is seen.
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] lane_mask;

`ifdef GPMC_BYTE_LANE_EN
  if (DATA_W == 16) begin : g_lane_en
    assign lane_mask = {{(DATA_W/2){~ben_dly[1]}}, {(DATA_W/2){~ben_dly[0]}}};
  end else begin : g_lane_full
    assign lane_mask = '1;
  end
`else
  assign lane_mask = '1;
`endif

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  gpmc_state_e       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wr_go;
  logic              err_set;
  logic              oe_d;

  always_ff @(posedge CLK_100M) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wr_go   = 1'b0;
    err_set = 1'b0;
    if (!wein_s && !oen_s) begin
      // Simultaneous WE and OE is illegal: flag it and drop the access.
      state_d = S_IDLE;
      err_set = 1'b1;
    end else if (csn_rise && (state_q != S_IDLE)) begin
      // Chip-select released mid-access: silent abort.
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!csn_s && !advn_s) state_d = S_ADDR;
        end
        S_ADDR: begin
          if (advn_rise) begin
            state_d = S_CMD;
            addr_d  = ad_dly[ADDR_W-1:0];
          end
        end
        S_CMD: begin
          if (!wein_s)     state_d = S_WRITE;
          else if (!oen_s) state_d = S_READ;
        end
        S_WRITE: begin
          if (wein_rise) begin
            state_d = S_IDLE;
            wr_go   = 1'b1;
          end
        end
        S_READ: begin
          if (oen_rise) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Drive the bus only while staying in READ, so OE drops the cycle after
  // the OE rising edge (or an abort) is seen.
  assign oe_d = (state_q == S_READ) && (state_d == S_READ);

  // --------------------------------------------------------------------------
  // Write pipeline: capture on the WE edge, commit one cycle later.
  // --------------------------------------------------------------------------
  logic              wr_pend_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic [DATA_W-1:0] wr_mask_q;
  logic [NUM_RW-1:0] wr_onehot;
  logic [NUM_RW-1:0] wr_strobe_q;
  logic              err_q;
  logic              oe_q;
  logic [DATA_W-1:0] ad_o_q;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] reg_file_q [NUM_RW];

  always_comb begin
    wr_onehot = '0;
    for (int i = 0; i < NUM_RW; i++) begin
      if (wr_addr_q == ADDR_W'(i)) wr_onehot[i] = 1'b1;
    end
  end

  always_ff @(posedge CLK_100M) begin
    if (reset) begin
      wr_pend_q   <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_mask_q   <= '0;
      wr_strobe_q <= '0;
      err_q       <= 1'b0;
      oe_q        <= 1'b0;
      ad_o_q      <= '0;
    end else begin
      // Read-only targets are dropped here, so they never strobe.
      wr_pend_q   <= wr_go && !is_ro_addr(32'(addr_q), NUM_RW);
      wr_addr_q   <= addr_q;
      wr_data_q   <= ad_dly;
      wr_mask_q   <= lane_mask;
      wr_strobe_q <= wr_pend_q ? wr_onehot : '0;
      if (err_set) err_q <= 1'b1;
      oe_q        <= oe_d;
      if (state_q == S_READ) ad_o_q <= rd_data;
    end
  end

  always_ff @(posedge CLK_100M) begin
    if (reset) begin
      for (int i = 0; i < NUM_RW; i++) begin
        reg_file_q[i] <= '0;
      end
    end else if (wr_pend_q) begin
      for (int i = 0; i < NUM_RW; i++) begin
        if (wr_addr_q == ADDR_W'(i)) begin
          reg_file_q[i] <= (reg_file_q[i] & ~wr_mask_q) | (wr_data_q & wr_mask_q);
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read mux: one entry per address so the index width matches exactly.
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] rd_tbl [NUM_REGS];

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_rd
    if (gi < NUM_RW) begin : g_rw
      assign rd_tbl[gi] = reg_file_q[gi];
    end else if (gi == NUM_REGS-1) begin : g_id
      assign rd_tbl[gi] = ID_VALUE[DATA_W-1:0];
    end else begin : g_st
      assign rd_tbl[gi] = status_i[(gi-NUM_RW)*DATA_W +: DATA_W];
    end
  end

  assign rd_data = rd_tbl[addr_q];

  for (genvar gi = 0; gi < NUM_RW; gi++) begin : g_flat
    assign ctrl_q[gi*DATA_W +: DATA_W] = reg_file_q[gi];
  end

  assign gpmc_ad_o  = ad_o_q;
  assign gpmc_ad_oe = oe_q;
  assign wr_strobe  = wr_strobe_q;
  assign proto_err  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_gpmc_regbank.sv
`default_nettype none
// ============================================================================
// Module      : tb_gpmc_regbank
// Description : Directed self-checking bench for gpmc_regbank with default
//               parameters (DATA_W=16, ADDR_W=4, NUM_RW=8, SYNC_STAGES=2).
//               Expected byte-lane result follows GPMC_BYTE_LANE_EN.
// Revision    : 1.0  initial release
// ============================================================================
module tb_gpmc_regbank;

  logic         clk = 1'b0;
  logic         reset;
  logic [15:0]  ad_i;
  logic [15:0]  ad_o;
  logic         ad_oe;
  logic         advn, csn, wein, oen;
  logic [1:0]   ben;
  logic [127:0] ctrl;
  logic [111:0] status;
  logic [7:0]   strobe;
  logic         perr;

  int n_cmp = 0;
  int n_err = 0;
  logic [127:0] exp_ctrl;
  logic [15:0]  v_lane;

  always #5 clk = ~clk;

  gpmc_regbank dut (
    .CLK_100M   (clk),
    .reset      (reset),
    .gpmc_ad_i  (ad_i),
    .gpmc_ad_o  (ad_o),
    .gpmc_ad_oe (ad_oe),
    .gpmc_advn  (advn),
    .gpmc_csn   (csn),
    .gpmc_wein  (wein),
    .gpmc_oen   (oen),
    .gpmc_ben   (ben),
    .ctrl_q     (ctrl),
    .status_i   (status),
    .wr_strobe  (strobe),
    .proto_err  (perr)
  );

  task automatic check_eq(input string tag, input logic [127:0] got,
                          input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Address phase: leaves CSN low, ADVN high, FSM in CMD.
  task automatic addr_phase(input logic [3:0] a);
    @(negedge clk);
    csn = 1'b0; advn = 1'b0; ad_i = {12'h000, a};
    cyc(5);
    advn = 1'b1;
    cyc(1);
  endtask

  // Full write with strobe latency checks (update lands 4 cycles after WE rises).
  task automatic host_write(input logic [3:0] a, input logic [15:0] d,
                            input logic [1:0] be, input logic [7:0] exp_stb);
    addr_phase(a);
    ad_i = d; ben = be;
    cyc(3);
    wein = 1'b0;
    cyc(5);
    wein = 1'b1;
    repeat (3) @(posedge clk);
    #1 check_eq("wr_stb_early", strobe, 8'h00);
    @(posedge clk);
    #1 check_eq("wr_stb_pulse", strobe, exp_stb);
    @(posedge clk);
    #1 check_eq("wr_stb_end", strobe, 8'h00);
    @(negedge clk);
    csn = 1'b1; ad_i = 16'h0000; ben = 2'b11;
    cyc(3);
  endtask

  // Full read with OE timing checks.
  task automatic host_read(input logic [3:0] a, input logic [15:0] exp_d);
    addr_phase(a);
    ad_i = 16'h0000;
    cyc(3);
    oen = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_eq("rd_oe_early", ad_oe, 1'b0);
    @(posedge clk);
    #1 check_eq("rd_oe_on", ad_oe, 1'b1);
    check_eq("rd_data", ad_o, exp_d);
    @(negedge clk);
    oen = 1'b1;
    repeat (2) @(posedge clk);
    #1 check_eq("rd_oe_hold", ad_oe, 1'b1);
    @(posedge clk);
    #1 check_eq("rd_oe_off", ad_oe, 1'b0);
    @(negedge clk);
    csn = 1'b1;
    cyc(3);
  endtask

  initial begin
    reset = 1'b1;
    ad_i = 16'h0000; advn = 1'b1; csn = 1'b1; wein = 1'b1; oen = 1'b1;
    ben = 2'b11;
    for (int k = 0; k < 7; k++) status[k*16 +: 16] = 16'h5000 + 16'(k);
    exp_ctrl = '0;
    cyc(4);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_eq("rst_ctrl",   ctrl,   128'h0);
    check_eq("rst_ad_o",   ad_o,   16'h0000);
    check_eq("rst_oe",     ad_oe,  1'b0);
    check_eq("rst_strobe", strobe, 8'h00);
    check_eq("rst_perr",   perr,   1'b0);

    // Basic write / readback
    host_write(4'd2, 16'h1234, 2'b00, 8'b0000_0100);
    exp_ctrl[47:32] = 16'h1234;
    check_eq("ctrl_a2", ctrl, exp_ctrl);
    host_read(4'd2, 16'h1234);
    host_read(4'd15, 16'hB33F);

    // Read-only target: dropped, status visible
    host_write(4'd9, 16'hFFFF, 2'b00, 8'h00);
    check_eq("ctrl_ro", ctrl, exp_ctrl);
    host_read(4'd9, 16'h5001);
    host_read(4'd14, 16'h5006);

    // Byte lanes
    host_write(4'd0, 16'h1111, 2'b00, 8'h01);
    exp_ctrl[15:0] = 16'h1111;
    check_eq("ctrl_a0", ctrl, exp_ctrl);
    host_write(4'd0, 16'hABCD, 2'b10, 8'h01);
`ifdef GPMC_BYTE_LANE_EN
    v_lane = 16'h11CD;
`else
    v_lane = 16'hABCD;
`endif
    exp_ctrl[15:0] = v_lane;
    check_eq("ctrl_lane", ctrl, exp_ctrl);

    // Highest R/W register
    host_write(4'd7, 16'hC0DE, 2'b00, 8'h80);
    exp_ctrl[127:112] = 16'hC0DE;
    check_eq("ctrl_a7", ctrl, exp_ctrl);
    host_read(4'd7, 16'hC0DE);

    // WE and OE together
    addr_phase(4'd4);
    cyc(3);
    wein = 1'b0; oen = 1'b0;
    cyc(5);
    check_eq("perr_set", perr, 1'b1);
    check_eq("perr_oe",  ad_oe, 1'b0);
    wein = 1'b1; oen = 1'b1;
    cyc(3);
    csn = 1'b1;
    cyc(3);
    check_eq("perr_sticky", perr, 1'b1);
    check_eq("perr_ctrl", ctrl, exp_ctrl);
    host_write(4'd5, 16'h5A5A, 2'b00, 8'h20);
    exp_ctrl[95:80] = 16'h5A5A;
    check_eq("ctrl_after_err", ctrl, exp_ctrl);

    // CSN released during WRITE
    addr_phase(4'd3);
    ad_i = 16'h7777; ben = 2'b00;
    cyc(3);
    wein = 1'b0;
    cyc(5);
    csn = 1'b1;
    cyc(4);
    wein = 1'b1;
    cyc(6);
    check_eq("abort_ctrl",   ctrl,   exp_ctrl);
    check_eq("abort_strobe", strobe, 8'h00);
    ad_i = 16'h0000; ben = 2'b11;
    host_read(4'd3, 16'h0000);

    // Reset in the middle of a read
    addr_phase(4'd15);
    ad_i = 16'h0000;
    cyc(3);
    oen = 1'b0;
    cyc(6);
    check_eq("mid_rd_oe", ad_oe, 1'b1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rst_rd_oe",   ad_oe, 1'b0);
    check_eq("rst_rd_ad",   ad_o,  16'h0000);
    check_eq("rst_rd_perr", perr,  1'b0);
    check_eq("rst_rd_ctrl", ctrl,  128'h0);
    @(negedge clk);
    oen = 1'b1; csn = 1'b1; advn = 1'b1;
    cyc(2);
    reset = 1'b0;
    cyc(4);
    check_eq("post_rst_oe", ad_oe, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gpmc_regbank.md
# gpmc_regbank

Parametrised GPMC slave register bank for the BeagleWire FPGA bridge. It decodes the asynchronous multiplexed address/data GPMC bus from the BeagleBone into a bank of read/write control registers and read-only status registers, all in the CLK_100M domain. All GPMC inputs are oversampled through synchronisers, and a state machine sequences address, write and read phases. It sits between the top-level GPMC pins and the user logic (LEDs, peripherals).

## Interface
Parameters:
- DATA_W, 16: GPMC data width; 8 or 16.
- ADDR_W, 4: register address bits; NUM_REGS = 2**ADDR_W.
- NUM_RW, 8: registers 0..NUM_RW-1 are R/W; NUM_RW..NUM_REGS-1 are read-only status.
- SYNC_STAGES, 2: synchroniser depth; minimum 2.
- ID_VALUE, 16'hB33F: value read from address NUM_REGS-1.

Ports:
- CLK_100M  in  1  system clock.
- reset  in  1  synchronous, active-high.
- gpmc_ad_i  in  DATA_W  AD bus, input path.
- gpmc_ad_o  out  DATA_W  AD bus, output path.
- gpmc_ad_oe  out  1  tristate enable for AD.
- gpmc_advn, gpmc_csn, gpmc_wein, gpmc_oen  in  1  each  active-low GPMC strobes.
- gpmc_ben  in  2  active-low byte enables.
- ctrl_q  out  NUM_RW*DATA_W  flattened R/W register contents.
- status_i  in  (NUM_REGS-NUM_RW-1)*DATA_W  status register inputs.
- wr_strobe  out  NUM_RW  one-cycle pulse per written register.
- proto_err  out  1  sticky protocol-error flag.

## Operation
- All strobes, gpmc_ben and gpmc_ad_i pass through SYNC_STAGES flops. Edge detection runs on the last stage against one extra delay flop.
- FSM states: IDLE, ADDR, CMD, WRITE, READ.
  - IDLE -> ADDR when synced csn=0 and advn=0.
  - ADDR -> CMD on the advn rising edge. The address latch takes the synced AD[ADDR_W-1:0] from the cycle before that edge.
  - CMD -> WRITE when wein=0. CMD -> READ when oen=0.
  - WRITE -> IDLE on the wein rising edge. The register at the latched address takes the synced AD captured in the cycle before that edge, and wr_strobe[addr] pulses for one cycle.
  - READ -> IDLE on the oen rising edge.
- Read data mux: ctrl_q for address < NUM_RW, status_i for addresses in between, ID_VALUE for NUM_REGS-1.
- Writes to read-only addresses are discarded; no strobe, no error.
- csn rising in any non-IDLE state -> IDLE with no write. This is an abort, not an error.
- wein=0 and oen=0 in the same synced cycle -> proto_err=1, FSM -> IDLE. proto_err clears only on reset.

## Timing
- Reset values:
  - ctrl_q: all 0.
  - gpmc_ad_o: 0.
  - gpmc_ad_oe: 0.
  - wr_strobe: 0.
  - proto_err: 0.
  - FSM: IDLE.
- Reset mid-transaction aborts it. A pending write is lost.
- Write latency: ctrl_q updates and wr_strobe pulses SYNC_STAGES+2 cycles after the pin-level wein rising edge.
- Read: gpmc_ad_o is registered. gpmc_ad_oe rises SYNC_STAGES+2 cycles after the pin-level oen falling edge and falls in the cycle after the synced oen rising edge is detected.
- Host GPMC timing must give ADVN, WEIN and OEN low pulses of at least SYNC_STAGES+2 CLK_100M cycles, and read access time of at least SYNC_STAGES+3 cycles.
- Back-to-back transactions: IDLE accepts a new advn low in the cycle after returning.

## Configuration
- GPMC_BYTE_LANE_EN defined: when DATA_W=16, each write updates only the byte lanes whose synced gpmc_ben bit is 0. A write with both lanes disabled still pulses wr_strobe.
- GPMC_BYTE_LANE_EN undefined: gpmc_ben is ignored and every write updates all DATA_W bits.

## Structure
- Package gpmc_pkg holds the FSM state encoding (3-bit localparams), the ID_VALUE default and the read-only address helper.
- Sub-module gpmc_sync: a generic SYNC_STAGES-deep synchroniser with rising/falling edge outputs, instantiated per strobe. A vector variant handles AD and ben.
- Register file and read mux stay inline.

## Test plan
- Write 16'h1234 to address 2 -> ctrl_q[47:32]=16'h1234, wr_strobe=3'b100 for one cycle, other registers unchanged.
- Read address 15 (defaults) -> gpmc_ad_o=16'hB33F while gpmc_ad_oe=1; oe low again after oen rises.
- Write 16'hFFFF to address 9 (read-only) -> no ctrl_q change, no strobe; a read of address 9 returns the matching status_i slice.
- With GPMC_BYTE_LANE_EN, write 16'hABCD with ben=2'b10 to address 0 holding 16'h1111 -> ctrl_q[15:0]=16'h11CD.
- Drive wein and oen low together -> proto_err=1 and stays set; a following valid write succeeds.
- Raise csn during WRITE before wein rises -> no register change, FSM in IDLE. Assert reset mid-read -> gpmc_ad_oe=0 on the next cycle.
